// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC switch output-port logic.
//   - FSM state encoding for the output-port channel holder
//   - default input count and flit width
//   - switch port index constants, in the same bit order the static
//     priority arbiter uses for its request/grant vectors
// ---------------------------------------------------------------------------
package noc_pkg;

    // Channel holder states
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // Default switch geometry
    localparam int NOC_IN_N   = 5;
    localparam int NOC_FLIT_W = 8;

    // Switch port indices (arbiter bit order)
    localparam int LOCAL = 0;
    localparam int EAST  = 1;
    localparam int SOUTH = 2;
    localparam int WEST  = 3;
    localparam int NORTH = 4;

endpackage

// File: rtl/flit_out_reg.sv
// ---------------------------------------------------------------------------
// flit_out_reg
// One-stage valid/ready output register for a switch output port.
// A flit is loaded whenever i_accept is high; the register empties when the
// downstream takes it and nothing new is loaded in the same cycle, so a
// simultaneous drain and load sustains one flit per cycle.
//
// Ports:
//   clk_i       clock (rising edge)
//   rst_ni      asynchronous active-low reset
//   i_accept    load i_data this cycle
//   i_data      flit to load
//   i_rdy       downstream ready
//   o_data      registered flit
//   o_vld       registered flit valid
//   o_can_take  register can accept a flit this cycle (!o_vld || i_rdy)
// ---------------------------------------------------------------------------
module flit_out_reg #(
    parameter int FLIT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_accept,
    input  logic [FLIT_W-1:0] i_data,
    input  logic              i_rdy,
    output logic [FLIT_W-1:0] o_data,
    output logic              o_vld,
    output logic              o_can_take
);

    logic [FLIT_W-1:0] r_data;
    logic              r_vld;

    // Load on accept; otherwise drop valid once the downstream consumed it.
    // Data is left in place when emptying so data_o only moves on a load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else if (i_accept) begin
            r_data <= i_data;
            r_vld  <= 1'b1;
        end else if (r_vld && i_rdy) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_data     = r_data;
    assign o_vld      = r_vld;
    assign o_can_take = !r_vld || i_rdy;

endmodule

// File: rtl/out_port_grant_ctrl.sv
// ---------------------------------------------------------------------------
// out_port_grant_ctrl
// Per-output-port channel holder. While free, it samples the arbiter's grant
// index and locks the output to that input for a whole packet, forwarding
// its flits through flit_out_reg and releasing after the tail is accepted.
//
// Optional feature macro: OUT_PORT_WATCHDOG_EN
//   When defined, a stall counter releases a lock that has seen no accept
//   for TIMEOUT_CYCLES-1 locked cycles and pulses err_o for one cycle.
//   When undefined, err_o is tied low and only a tail flit releases the lock.
//
// Ports:
//   clk_i      clock (rising edge)
//   rst_ni     asynchronous active-low reset
//   vld_i      per-input flit valid (also the arbiter request vector)
//   last_i     per-input tail marker, qualified by vld_i
//   data_i     flattened input flits, input k at [k*FLIT_W +: FLIT_W]
//   arb_res_i  arbiter result index, meaningful only while |vld_i
//   rdy_o      per-input ready, one-hot or zero
//   data_o     registered output flit
//   vld_o      output flit valid
//   rdy_i      downstream ready
//   busy_o     channel is locked
//   err_o      one-cycle watchdog release pulse
// ---------------------------------------------------------------------------
module out_port_grant_ctrl
    import noc_pkg::*;
#(
    parameter int IN_N           = NOC_IN_N,
    parameter int FLIT_W         = NOC_FLIT_W,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int IDX_W         = (IN_N > 1) ? $clog2(IN_N) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [IN_N-1:0]        vld_i,
    input  logic [IN_N-1:0]        last_i,
    input  logic [IN_N*FLIT_W-1:0] data_i,
    input  logic [IDX_W-1:0]       arb_res_i,
    output logic [IN_N-1:0]        rdy_o,
    output logic [FLIT_W-1:0]      data_o,
    output logic                   vld_o,
    input  logic                   rdy_i,
    output logic                   busy_o,
    output logic                   err_o
);

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_grant_q;

    logic              w_locked;
    logic              w_sel_vld;
    logic              w_sel_last;
    logic [FLIT_W-1:0] w_sel_data;
    logic              w_arb_ok;
    logic              w_can_take;
    logic              w_accept;
    logic              w_wd_fire;

    assign w_locked = (r_state == LOCKED);

    // Select the granted input's lane, and check that the arbiter result
    // names an in-range input that is actually requesting.
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = '0;
        w_arb_ok   = 1'b0;
        rdy_o      = '0;
        for (int k = 0; k < IN_N; k++) begin
            if (r_grant_q == IDX_W'(k)) begin
                w_sel_vld  = vld_i[k];
                w_sel_last = last_i[k];
                w_sel_data = data_i[k*FLIT_W +: FLIT_W];
                rdy_o[k]   = w_locked && w_can_take;
            end
            if (arb_res_i == IDX_W'(k)) begin
                w_arb_ok = vld_i[k];
            end
        end
    end

    assign w_accept = w_locked && w_sel_vld && w_can_take;
    assign busy_o   = w_locked;

    // Lock on a valid grant; release on the tail accept or a watchdog expiry.
    // Release always passes through IDLE, which gives the inter-packet bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_grant_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|vld_i && w_arb_ok) begin
                        r_state   <= LOCKED;
                        r_grant_q <= arb_res_i;
                    end
                end
                LOCKED: begin
                    if ((w_accept && w_sel_last) || w_wd_fire) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef OUT_PORT_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_err;

    // Fires on the edge where the stall count steps up to TIMEOUT_CYCLES-1.
    assign w_wd_fire = w_locked && !w_accept
                       && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    // Holding the count at zero in IDLE clears it on entry to LOCKED.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_wd_fire;
            if (!w_locked || w_accept) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_wd_fire = 1'b0;
    assign err_o     = 1'b0;
`endif

    flit_out_reg #(
        .FLIT_W (FLIT_W)
    ) u_flit_out_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_accept   (w_accept),
        .i_data     (w_sel_data),
        .i_rdy      (rdy_i),
        .o_data     (data_o),
        .o_vld      (vld_o),
        .o_can_take (w_can_take)
    );

endmodule
